// File: rtl/control_vector_sequencer_if.sv
// Instruction/beat bus for the control vector sequencer.
// Purpose: bundles the instruction handshake, the downstream stall/flush controls and the
//          per-beat control outputs into one interface.
// Signals:
//   in_valid/in_ready   instruction handshake; opcode (5 bits) and vl (IW+1 bits) travel with it
//   stall, flush        downstream hold and abort
//   out_valid           a beat is presented, with RegDst, MemtoReg, RegWrite, MemRead, MemWrite,
//                       TipoInstr, ALUOperation, elem_idx, lane_mask and last
//   illegal             one-cycle pulse after accepting an unrecognised opcode
// Modports: master drives instructions and stall/flush; slave is the sequencer.
interface control_vector_sequencer_if #(
   parameter int unsigned VLEN  = 8,
   parameter int unsigned LANES = 2
);
   localparam int unsigned IW = $clog2(VLEN);

   logic             in_valid;
   logic             in_ready;
   logic [4:0]       opcode;
   logic [IW:0]      vl;
   logic             stall;
   logic             flush;
   logic             out_valid;
   logic             RegDst;
   logic             MemtoReg;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             TipoInstr;
   logic [3:0]       ALUOperation;
   logic [IW-1:0]    elem_idx;
   logic [LANES-1:0] lane_mask;
   logic             last;
   logic             illegal;

   modport master (
      output in_valid, opcode, vl, stall, flush,
      input  in_ready, out_valid, RegDst, MemtoReg, RegWrite, MemRead, MemWrite, TipoInstr,
      input  ALUOperation, elem_idx, lane_mask, last, illegal
   );

   modport slave (
      input  in_valid, opcode, vl, stall, flush,
      output in_ready, out_valid, RegDst, MemtoReg, RegWrite, MemRead, MemWrite, TipoInstr,
      output ALUOperation, elem_idx, lane_mask, last, illegal
   );
endinterface

// File: rtl/control_vector_sequencer.sv
// Control vector sequencer.
// Purpose: accepts one vector instruction at a time, decodes its opcode into datapath controls
//          and issues it as ceil(min(vl, VLEN) / LANES) beats of LANES elements each, with a
//          lane mask covering the partial final beat.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of control_vector_sequencer_if (handshake, stall/flush, beat outputs)
module control_vector_sequencer #(
   parameter int unsigned VLEN  = 8,
   parameter int unsigned LANES = 2
) (
   input logic                       clk,
   input logic                       rst_n,
   control_vector_sequencer_if.slave bus
);
   localparam int unsigned IW = $clog2(VLEN);

   typedef enum logic [0:0] {st_idle, st_issue} state_t;

   typedef struct packed {
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [3:0] aluop;
   } ctrl_t;

   state_t           state_q;
   logic [IW-1:0]    base_q;
   logic [IW:0]      evl_q;
   ctrl_t            dec_q;
   logic             illegal_q;

   ctrl_t            dec;
   logic             dec_legal;
   logic [IW:0]      evl;
   logic             accept;
   logic             issuing;
   logic             last_beat;
   logic [LANES-1:0] mask;
   logic [IW+1:0]    base_ext;
   logic [IW+1:0]    evl_ext;

   // Opcode decode; anything outside the table is illegal.
   always_comb begin
      dec       = '0;
      dec_legal = 1'b1;
      case (bus.opcode)
         5'b00010: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001}; // ADDV
         5'b10001: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100}; // SUBV
         5'b00110: dec = ctrl_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010}; // XORIV
         5'b01110: dec = ctrl_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000}; // LOADV
         5'b10000: dec = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000}; // STOREV
         5'b00100: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011}; // MOVV
         5'b01001: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101}; // LSLV
         5'b01010: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110}; // LSRV
         5'b00111: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111}; // RORV
         5'b01000: dec = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000}; // ROLV
         default:  dec_legal = 1'b0;
      endcase
   end

   // Requested lengths beyond VLEN are clamped.
   assign evl = (bus.vl > (IW+1)'(VLEN)) ? (IW+1)'(VLEN) : bus.vl;

   assign bus.in_ready = (state_q == st_idle) & ~bus.flush;
   assign accept       = bus.in_valid & (state_q == st_idle) & ~bus.flush;
   assign issuing      = (state_q == st_issue);

   // Two extra bits so base + LANES cannot wrap when LANES == VLEN.
   assign base_ext  = {2'b00, base_q};
   assign evl_ext   = {1'b0, evl_q};
   assign last_beat = (base_ext + (IW+2)'(LANES)) >= evl_ext;

   always_comb begin
      mask = '0;
      for (int i = 0; i < LANES; i++) begin
         mask[i] = (base_ext + (IW+2)'(i)) < evl_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= st_idle;
         base_q    <= '0;
         evl_q     <= '0;
         dec_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         if (bus.flush) begin
            // Flush wins over both stall and a simultaneous accept.
            state_q <= st_idle;
            base_q  <= '0;
         end else begin
            case (state_q)
               st_idle: begin
                  if (accept) begin
                     if (!dec_legal) begin
                        illegal_q <= 1'b1;
                     end else if (evl != '0) begin
                        state_q <= st_issue;
                        base_q  <= '0;
                        dec_q   <= dec;
                        evl_q   <= evl;
                     end
                  end
               end
               st_issue: begin
                  if (!bus.stall) begin
                     if (last_beat) begin
                        state_q <= st_idle;
                        base_q  <= '0;
                     end else begin
                        // Only reached when base + LANES < VLEN, so the truncation is exact.
                        base_q <= base_q + IW'(LANES);
                     end
                  end
               end
               default: state_q <= st_idle;
            endcase
         end
      end
   end

   // Every beat output reads zero whenever no beat is presented.
   assign bus.out_valid    = issuing;
   assign bus.RegDst       = issuing & dec_q.regdst;
   assign bus.MemtoReg     = issuing & dec_q.memtoreg;
   assign bus.RegWrite     = issuing & dec_q.regwrite;
   assign bus.MemRead      = issuing & dec_q.memread;
   assign bus.MemWrite     = issuing & dec_q.memwrite;
   assign bus.TipoInstr    = issuing;
   assign bus.ALUOperation = issuing ? dec_q.aluop : 4'b0000;
   assign bus.elem_idx     = issuing ? base_q : '0;
   assign bus.lane_mask    = issuing ? mask : '0;
   assign bus.last         = issuing & last_beat;
   assign bus.illegal      = illegal_q;
endmodule
